// File: rtl/fb_scanout_if.sv
// Scan-out bus: frame buffer read port, renderer swap handshake and VGA pins.
// master = scan-out engine, slave = the memory/renderer/display side.
interface fb_scanout_if;
  logic [19:0] read_addr;
  logic        fb_r, fb_g, fb_b;
  logic        swap_req, swap_ack;
  logic        front_sel, frame_start;
  logic        vga_r, vga_g, vga_b;
  logic        hsync, vsync, de;

  modport master (
    output read_addr, swap_ack, front_sel, frame_start,
    output vga_r, vga_g, vga_b, hsync, vsync, de,
    input  fb_r, fb_g, fb_b, swap_req
  );

  modport slave (
    input  read_addr, swap_ack, front_sel, frame_start,
    input  vga_r, vga_g, vga_b, hsync, vsync, de,
    output fb_r, fb_g, fb_b, swap_req
  );
endinterface

// File: rtl/fb_scanout.sv
// VGA scan-out for a double-buffered frame buffer. Generates raster timing,
// walks a linear read address through the front buffer, aligns returning
// pixel data with sync/de through a 3-stage pipe and flips buffers at the
// start of vertical blanking when the renderer asks.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_SIZE  = 307200
) (
  input  logic             clk,
  input  logic             reset,
  fb_scanout_if.master     bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [19:0]   BASE1  = 20'(FB_SIZE);

  // S0 state
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]   lin_q, lin_d;
  logic          front_sel_q, front_sel_d;
  logic          swap_ack_q, swap_ack_d;
  logic          frame_start_q, frame_start_d;
  // S1: raster flags held while the memory read is in flight
  logic          act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  // S2: output registers
  logic          vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic          de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;

  logic active, h_wrap, v_wrap, hs_raw, vs_raw, swap_pt;

  // Raster decode and next-state for counters, swap logic and pipeline
  always_comb begin
    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    hs_raw  = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
    vs_raw  = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
    // First blanking cycle: every pixel of the frame has left the pipe
    swap_pt = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;

    // lin tracks v*H_ACTIVE+h by counting consumed pixels
    lin_d = lin_q;
    if (h_wrap && v_wrap) lin_d = '0;
    else if (active)      lin_d = lin_q + 1'b1;

    front_sel_d   = front_sel_q ^ (swap_pt & bus.swap_req);
    swap_ack_d    = swap_pt & bus.swap_req;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

    act1_d  = active;
    hs1_d   = hs_raw;
    vs1_d   = vs_raw;

    vga_r_d = act1_q & bus.fb_r;
    vga_g_d = act1_q & bus.fb_g;
    vga_b_d = act1_q & bus.fb_b;
    de_d    = act1_q;
    hsync_d = hs1_q;
    vsync_d = vs1_q;
  end

  // State registers; delay stages reset to the inactive (blank, sync high) value
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;  v_cnt_q <= '0;  lin_q <= '0;
      front_sel_q <= 1'b0;  swap_ack_q <= 1'b0;  frame_start_q <= 1'b0;
      act1_q <= 1'b0;  hs1_q <= 1'b1;  vs1_q <= 1'b1;
      vga_r_q <= 1'b0;  vga_g_q <= 1'b0;  vga_b_q <= 1'b0;
      de_q <= 1'b0;  hsync_q <= 1'b1;  vsync_q <= 1'b1;
    end else begin
      h_cnt_q <= h_cnt_d;  v_cnt_q <= v_cnt_d;  lin_q <= lin_d;
      front_sel_q <= front_sel_d;  swap_ack_q <= swap_ack_d;
      frame_start_q <= frame_start_d;
      act1_q <= act1_d;  hs1_q <= hs1_d;  vs1_q <= vs1_d;
      vga_r_q <= vga_r_d;  vga_g_q <= vga_g_d;  vga_b_q <= vga_b_d;
      de_q <= de_d;  hsync_q <= hsync_d;  vsync_q <= vsync_d;
    end
  end

  assign bus.read_addr   = (front_sel_q ? BASE1 : 20'd0) + {1'b0, lin_q};
  assign bus.front_sel   = front_sel_q;
  assign bus.swap_ack    = swap_ack_q;
  assign bus.frame_start = frame_start_q;
  assign bus.vga_r       = vga_r_q;
  assign bus.vga_g       = vga_g_q;
  assign bus.vga_b       = vga_b_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout using a shrunken raster (16x11 total,
// 8x6 visible) so whole frames run in a few hundred cycles.
module tb_fb_scanout;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 16
  localparam int VT = VA + VFP + VS + VBP;   // 11
  localparam int FT = HT * VT;               // 176
  localparam int FBS = HA * VA;              // 48

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  fb_scanout_if bus();

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FB_SIZE(FBS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Test pattern {r,g,b}; low address bits so it varies in the small raster
  function automatic logic [2:0] pat(input logic [19:0] a);
    return {a[0] ^ a[3], ~a[0], a[1] ^ a[2]};
  endfunction

  // Frame buffer model: one clock read latency
  always @(posedge clk) {bus.fb_r, bus.fb_g, bus.fb_b} <= pat(bus.read_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: counters at (0,0), reset released
  task automatic do_reset();
    reset = 1'b1;
    bus.swap_req = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.swap_req = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (bus.read_addr !== 20'd0) begin
      n_fail++; $display("FAIL rst_addr: got %0d want 0", bus.read_addr);
    end
    n_chk++;
    if ({bus.hsync, bus.vsync, bus.de, bus.vga_r, bus.vga_g, bus.vga_b} !== 6'b110000) begin
      n_fail++; $display("FAIL rst_video: got %b want 110000",
        {bus.hsync, bus.vsync, bus.de, bus.vga_r, bus.vga_g, bus.vga_b});
    end
    n_chk++;
    if ({bus.front_sel, bus.swap_ack, bus.frame_start} !== 3'b000) begin
      n_fail++; $display("FAIL rst_ctrl: got %b want 000",
        {bus.front_sel, bus.swap_ack, bus.frame_start});
    end
    reset = 1'b0;
    tick();
    n_chk++;
    if (bus.read_addr !== 20'd1) begin
      n_fail++; $display("FAIL rel_addr: got %0d want 1", bus.read_addr);
    end
    n_chk++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++; $display("FAIL rel_fs: got %b want 1", bus.frame_start);
    end
  endtask

  task automatic test_line_timing();
    int first_de = -1, second_de = -1, de_cnt = 0, hs_fall = -1, hs_len = 0;
    logic pde = 1'b0, phs = 1'b1;
    do_reset();
    for (int c = 0; c < HT + 4; c++) begin
      if (c > 0) tick();
      if (bus.de && !pde) begin
        if (first_de < 0) first_de = c;
        else if (second_de < 0) second_de = c;
      end
      if (bus.de && c < HT + 2) de_cnt++;
      if (!bus.hsync && phs && hs_fall < 0) hs_fall = c;
      if (!bus.hsync && c < HT + 2) hs_len++;
      pde = bus.de;
      phs = bus.hsync;
    end
    n_chk++;
    if (first_de != 2) begin
      n_fail++; $display("FAIL de_start: got %0d want 2", first_de);
    end
    n_chk++;
    if (de_cnt != HA) begin
      n_fail++; $display("FAIL de_len: got %0d want %0d", de_cnt, HA);
    end
    n_chk++;
    if (second_de != HT + 2) begin
      n_fail++; $display("FAIL line_period: got %0d want %0d", second_de, HT + 2);
    end
    n_chk++;
    if (hs_fall != HA + HFP + 2) begin
      n_fail++; $display("FAIL hs_fall: got %0d want %0d", hs_fall, HA + HFP + 2);
    end
    n_chk++;
    if (hs_len != HS) begin
      n_fail++; $display("FAIL hs_len: got %0d want %0d", hs_len, HS);
    end
  endtask

  task automatic test_frame_timing();
    int fs1 = -1, fs2 = -1, vs_fall = -1, vs_len = 0;
    logic pvs = 1'b1;
    do_reset();
    for (int c = 0; c < 2 * FT + 2; c++) begin
      if (c > 0) tick();
      if (bus.frame_start) begin
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
      if (!bus.vsync && pvs && vs_fall < 0) vs_fall = c;
      if (!bus.vsync && c < FT) vs_len++;
      pvs = bus.vsync;
      if (c == (VA - 1) * HT) begin
        n_chk++;
        if (bus.read_addr !== 20'((VA - 1) * HA)) begin
          n_fail++; $display("FAIL addr_last_line: got %0d want %0d", bus.read_addr, (VA - 1) * HA);
        end
      end
      if (c == (VA - 1) * HT + HA - 1) begin
        n_chk++;
        if (bus.read_addr !== 20'(FBS - 1)) begin
          n_fail++; $display("FAIL addr_last_pix: got %0d want %0d", bus.read_addr, FBS - 1);
        end
      end
      if (c == VA * HT + 5) begin
        n_chk++;
        if (bus.read_addr !== 20'(FBS)) begin
          n_fail++; $display("FAIL addr_blank: got %0d want %0d", bus.read_addr, FBS);
        end
      end
      if (c == FT) begin
        n_chk++;
        if (bus.read_addr !== 20'd0) begin
          n_fail++; $display("FAIL addr_wrap: got %0d want 0", bus.read_addr);
        end
      end
    end
    n_chk++;
    if (fs1 != 1 || fs2 != FT + 1) begin
      n_fail++; $display("FAIL frame_start: got %0d,%0d want 1,%0d", fs1, fs2, FT + 1);
    end
    n_chk++;
    if (vs_fall != (VA + VFP) * HT + 2) begin
      n_fail++; $display("FAIL vs_fall: got %0d want %0d", vs_fall, (VA + VFP) * HT + 2);
    end
    n_chk++;
    if (vs_len != VS * HT) begin
      n_fail++; $display("FAIL vs_len: got %0d want %0d", vs_len, VS * HT);
    end
  endtask

  // Every output compared each cycle against the raster position two cycles back
  task automatic test_data_align();
    int errs = 0, bad_c = -1;
    logic [6:0] got, exp, bad_got, bad_exp;
    bad_got = '0;
    bad_exp = '0;
    do_reset();
    for (int c = 0; c < FT + 4; c++) begin
      logic [2:0] ev;
      logic ede, ehs, evs, efs;
      if (c > 0) tick();
      if (c >= 2) begin
        int pc, h, v;
        logic act;
        pc  = c - 2;
        h   = pc % HT;
        v   = (pc / HT) % VT;
        act = (h < HA) && (v < VA);
        ev  = act ? pat(20'(v * HA + h)) : 3'b000;
        ede = act;
        ehs = !(h >= HA + HFP && h < HA + HFP + HS);
        evs = !(v >= VA + VFP && v < VA + VFP + VS);
      end else begin
        ev = 3'b000; ede = 1'b0; ehs = 1'b1; evs = 1'b1;
      end
      efs = (c >= 1) && ((c - 1) % FT == 0);
      got = {bus.vga_r, bus.vga_g, bus.vga_b, bus.de, bus.hsync, bus.vsync, bus.frame_start};
      exp = {ev, ede, ehs, evs, efs};
      if (got !== exp) begin
        if (errs == 0) begin bad_c = c; bad_got = got; bad_exp = exp; end
        errs++;
      end
    end
    n_chk++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL align: %0d bad cycles, first c=%0d got rgb/de/hs/vs/fs=%b want %b",
        errs, bad_c, bad_got, bad_exp);
    end
  endtask

  task automatic test_swap();
    int acks = 0;
    do_reset();
    for (int c = 0; c < FT + 3; c++) begin
      if (c > 0) tick();
      if (bus.swap_ack) acks++;
      if (c == VA * HT) begin
        n_chk++;
        if (bus.front_sel !== 1'b0) begin
          n_fail++; $display("FAIL swap_pre: got %b want 0", bus.front_sel);
        end
      end
      if (c == VA * HT + 1) begin
        n_chk++;
        if ({bus.front_sel, bus.swap_ack} !== 2'b11) begin
          n_fail++; $display("FAIL swap_edge: got sel/ack=%b want 11", {bus.front_sel, bus.swap_ack});
        end
        bus.swap_req = 1'b0;
      end
      if (c == FT) begin
        n_chk++;
        if (bus.read_addr !== 20'(FBS)) begin
          n_fail++; $display("FAIL swap_base: got %0d want %0d", bus.read_addr, FBS);
        end
      end
      if (c == 3 * HT) bus.swap_req = 1'b1;
    end
    n_chk++;
    if (acks != 1) begin
      n_fail++; $display("FAIL swap_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_no_swap();
    int acks = 0, toggles = 0;
    logic psel = 1'b0;
    do_reset();
    for (int c = 0; c < FT + 3; c++) begin
      if (c > 0) tick();
      if (bus.swap_ack) acks++;
      if (bus.front_sel !== psel) toggles++;
      psel = bus.front_sel;
      if (c == FT) begin
        n_chk++;
        if (bus.read_addr !== 20'd0) begin
          n_fail++; $display("FAIL noswap_base: got %0d want 0", bus.read_addr);
        end
      end
    end
    n_chk++;
    if (acks != 0 || toggles != 0) begin
      n_fail++; $display("FAIL noswap: got acks=%0d toggles=%0d want 0,0", acks, toggles);
    end
  endtask

  task automatic test_swap_multi();
    int acks = 0;
    do_reset();
    bus.swap_req = 1'b1;
    for (int c = 0; c < 3 * FT; c++) begin
      if (c > 0) tick();
      if (bus.swap_ack) acks++;
      if (c == FT) begin
        n_chk++;
        if (bus.read_addr !== 20'(FBS)) begin
          n_fail++; $display("FAIL multi_f1: got %0d want %0d", bus.read_addr, FBS);
        end
      end
      if (c == 2 * FT) begin
        n_chk++;
        if (bus.read_addr !== 20'd0) begin
          n_fail++; $display("FAIL multi_f2: got %0d want 0", bus.read_addr);
        end
      end
    end
    bus.swap_req = 1'b0;
    n_chk++;
    if (acks != 3 || bus.front_sel !== 1'b1) begin
      n_fail++; $display("FAIL multi_acks: got acks=%0d sel=%b want 3,1", acks, bus.front_sel);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.swap_req = 1'b1;
    for (int c = 1; c <= FT + 2 * HT + 3; c++) tick();
    n_chk++;
    if (bus.front_sel !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got %b want 1", bus.front_sel);
    end
    reset = 1'b1;
    tick();
    n_chk++;
    if (bus.read_addr !== 20'd0) begin
      n_fail++; $display("FAIL mid_addr: got %0d want 0", bus.read_addr);
    end
    n_chk++;
    if ({bus.hsync, bus.vsync, bus.de, bus.vga_r, bus.vga_g, bus.vga_b} !== 6'b110000) begin
      n_fail++; $display("FAIL mid_video: got %b want 110000",
        {bus.hsync, bus.vsync, bus.de, bus.vga_r, bus.vga_g, bus.vga_b});
    end
    n_chk++;
    if ({bus.front_sel, bus.swap_ack, bus.frame_start} !== 3'b000) begin
      n_fail++; $display("FAIL mid_ctrl: got %b want 000",
        {bus.front_sel, bus.swap_ack, bus.frame_start});
    end
    tick();
    n_chk++;
    if (bus.swap_ack !== 1'b0) begin
      n_fail++; $display("FAIL mid_noack: got %b want 0", bus.swap_ack);
    end
    reset = 1'b0;
    bus.swap_req = 1'b0;
    tick();
    n_chk++;
    if ({bus.frame_start, bus.read_addr} !== {1'b1, 20'd1}) begin
      n_fail++; $display("FAIL mid_restart: got fs=%b addr=%0d want fs=1 addr=1",
        bus.frame_start, bus.read_addr);
    end
  endtask

  initial begin
    bus.swap_req = 1'b0;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_data_align();
    test_swap();
    test_no_swap();
    test_swap_multi();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display scan-out stage for the double-buffered frame buffer. It generates 640x480@60 VGA timing and drives the frame buffer's 20-bit read address for the current front buffer. It registers the 1-bit R/G/B data that comes back into pixel outputs aligned with hsync/vsync. On request it swaps front and back buffers at the start of vertical blanking, so the renderer never sees a torn frame.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- FB_SIZE, 307200, words per buffer; buffer 1 base address

Ports:
- clk  in  1  pixel clock; the single clock of the block
- reset  in  1  reset; synchronous and active-high
- read_addr  out  20  frame buffer read address
- fb_r, fb_g, fb_b  in  1 each  frame buffer read data; valid 1 clk after read_addr
- swap_req  in  1  level; renderer has a finished back buffer
- swap_ack  out  1  1-cycle pulse; swap performed
- front_sel  out  1  buffer being displayed (0: base 0, 1: base FB_SIZE)
- frame_start  out  1  1-cycle pulse at h_cnt=0, v_cnt=0
- vga_r, vga_g, vga_b  out  1 each  pixel outputs
- hsync, vsync  out  1 each  active-low sync
- de  out  1  display enable, aligned with vga_*

## Operation
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800.
- v_cnt advances when h_cnt wraps and counts 0..V_TOTAL-1, where V_TOTAL=525.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync_raw is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync_raw is low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Linear counter lin (19 bits):
  - increments by 1 after each active pixel;
  - clears to 0 when v_cnt wraps.
  - No multiplier is used.
- read_addr = (front_sel ? FB_SIZE : 0) + lin, computed combinationally from registers.
  - During an active pixel (h,v): read_addr = base + v*640 + h.
  - Outside the active region: read_addr = base + lin (next pixel address). The frame buffer ignores it.
- Swap check happens at h_cnt=0, v_cnt=V_ACTIVE (first blanking cycle):
  - if swap_req=1: front_sel toggles at that edge, and swap_ack=1 for exactly the next cycle;
  - if swap_req=0: no change.
  - swap_req is ignored at every other cycle. A request held across several frames swaps once per frame.
- Pipeline, 3 stages:
  - S0: counters, lin, read_addr.
  - S1: active, hsync_raw and vsync_raw delayed 1 clk while memory reads.
  - S2: output registers. vga_* = fb_* when the delayed active bit is set, else 0. hsync, vsync and de are the 2-clk-delayed raw values.
- Reset values:
  - h_cnt = v_cnt = lin = 0, front_sel = 0;
  - vga_* = 0, de = 0, hsync = vsync = 1;
  - swap_ack = 0, frame_start = 0;
  - delay registers are set to the inactive value.
- Reset mid-frame: all state returns to reset values at the next edge. No swap_ack is issued. The frame restarts from (0,0) one cycle after reset drops.

## Timing
- Address to pixel latency is 2 clk. read_addr for pixel (h,v) is presented in cycle t. fb_* is valid in t+1. vga_*/de for that pixel appear in t+2.
- hsync and vsync also carry exactly 2 clk delay relative to the counters, so sync-to-pixel relations match standard VGA.
- frame_start is registered and asserts for the cycle following h_cnt=0, v_cnt=0. It is 1 cycle before the first pixel of the frame reaches vga_*.
- Frame period: 800 x 525 = 420000 clk. Line period: 800 clk.
- front_sel never changes while any pixel in the S0..S2 pipeline is active. The swap point is 160 clk after the last active pixel.
- Wrap conditions:
  - h_cnt=799 gives h_cnt=0, and v_cnt advances.
  - h_cnt=799 and v_cnt=524 gives (0,0), and lin clears.

## Test plan
- Reset: hold reset 3 clk. Check outputs: read_addr=0, hsync=vsync=1, de=0, vga_*=0, front_sel=0, swap_ack=0. Release reset. Check read_addr=1 after 1 clk (pixel 0 consumed).
- Line timing: over one line, de=1 for 640 clk starting 2 clk after h_cnt=0. hsync goes low at h_cnt=658 and stays low for 96 clk. Line period is 800 clk.
- Frame timing and addressing:
  - frame_start pulses every 420000 clk;
  - vsync is low for 1600 clk beginning at line 490;
  - read_addr at the first pixel of line 479 = 306560;
  - read_addr at the last active pixel = 307199.
- Data alignment: drive fb_* from a 1-clk-latency memory model loaded with pattern bit = addr[0]^addr[10]. vga_* must match the model exactly at every de=1 cycle, and be 0 when de=0.
- Swap:
  - swap_req=1 held from frame mid: front_sel toggles at line 480 h=0, and swap_ack pulses once. The next frame's first read_addr is 307200.
  - swap_req=0: no toggle and no ack.
  - swap_req held 3 frames: exactly 3 acks.
- Reset mid-frame at line 200: all outputs return to reset values next edge, and front_sel=0. After release, frame_start occurs after 1 clk and addressing restarts at 0.
